// File: rtl/ntt_butterfly_pipe.sv
// 3-stage modular NTT butterfly (CT forward / GS inverse) with valid/ready flow.
// Define NTT_BFLY_GS_HALVE_EN to scale both GS results by 1/2 mod Q.
module ntt_butterfly_pipe #(
    parameter int WIDTH = 32,
    parameter int Q     = 3329,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [TAG_W-1:0] out_tag,
    output logic             idle,
    output logic             range_err
);

    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
    localparam logic [PW-1:0]    QP = PW'(Q);

    logic advance;
    logic in_fire;
    logic in_bad;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign in_fire  = in_valid && advance;
    assign in_bad   = (in_a >= QW) || (in_b >= QW) || (in_w >= QW);

    logic             s1_v, s2_v;
    logic             s1_m, s2_m;
    logic [TAG_W-1:0] s1_t, s2_t;
    logic [PW-1:0]    s1_p, s2_p;
    logic [WIDTH-1:0] s1_x, s1_w, s2_x;

    // S1: CT keeps w*b with a alongside; GS keeps (a+b) in p and (a-b) in x
    logic [WIDTH:0]   ab_sum;
    logic [WIDTH-1:0] ab_add;
    logic [WIDTH-1:0] ab_sub;
    logic [PW-1:0]    s1_p_d;
    logic [WIDTH-1:0] s1_x_d;

    always_comb begin
        ab_sum = {1'b0, in_a} + {1'b0, in_b};
        ab_add = (ab_sum >= {1'b0, QW}) ? WIDTH'(ab_sum - {1'b0, QW})
                                        : ab_sum[WIDTH-1:0];
        ab_sub = (in_a >= in_b) ? in_a - in_b : in_a - in_b + QW;
        if (in_mode) begin
            s1_p_d = {{WIDTH{1'b0}}, ab_add};
            s1_x_d = ab_sub;
        end else begin
            s1_p_d = PW'(in_w) * PW'(in_b);
            s1_x_d = in_a;
        end
    end

    logic [PW-1:0]    s2_p_d;
    logic [WIDTH-1:0] s2_x_d;

    always_comb begin
        if (s1_m) begin
            s2_p_d = PW'(s1_x) * PW'(s1_w);
            s2_x_d = s1_p[WIDTH-1:0];
        end else begin
            s2_p_d = s1_p % QP;
            s2_x_d = s1_x;
        end
    end

`ifdef NTT_BFLY_GS_HALVE_EN
    function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] e;
        e = {1'b0, x} + (x[0] ? {1'b0, QW} : '0);
        return e[WIDTH:1];
    endfunction
`endif

    logic [WIDTH-1:0] ct_t;
    logic [WIDTH:0]   ct_sum;
    logic [WIDTH-1:0] gs_b;
    logic [WIDTH-1:0] s3_a_d, s3_b_d;

    always_comb begin
        ct_t   = s2_p[WIDTH-1:0];
        ct_sum = {1'b0, s2_x} + {1'b0, ct_t};
        gs_b   = WIDTH'(s2_p % QP);
        if (s2_m) begin
`ifdef NTT_BFLY_GS_HALVE_EN
            s3_a_d = halve(s2_x);
            s3_b_d = halve(gs_b);
`else
            s3_a_d = s2_x;
            s3_b_d = gs_b;
`endif
        end else begin
            s3_a_d = (ct_sum >= {1'b0, QW}) ? WIDTH'(ct_sum - {1'b0, QW})
                                            : ct_sum[WIDTH-1:0];
            s3_b_d = (s2_x >= ct_t) ? s2_x - ct_t : s2_x - ct_t + QW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            out_valid <= 1'b0;
            s1_m      <= 1'b0;
            s2_m      <= 1'b0;
            s1_t      <= '0;
            s2_t      <= '0;
            s1_p      <= '0;
            s1_x      <= '0;
            s1_w      <= '0;
            s2_p      <= '0;
            s2_x      <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_tag   <= '0;
            range_err <= 1'b0;
        end else begin
            if (in_fire && in_bad) begin
                range_err <= 1'b1;
            end
            if (advance) begin
                s1_v      <= in_valid;
                s1_m      <= in_mode;
                s1_t      <= in_tag;
                s1_p      <= s1_p_d;
                s1_x      <= s1_x_d;
                s1_w      <= in_w;
                s2_v      <= s1_v;
                s2_m      <= s1_m;
                s2_t      <= s1_t;
                s2_p      <= s2_p_d;
                s2_x      <= s2_x_d;
                out_valid <= s2_v;
                out_tag   <= s2_t;
                out_a     <= s3_a_d;
                out_b     <= s3_b_d;
            end
        end
    end

    assign idle = !(s1_v || s2_v || out_valid);

endmodule
